// File: rtl/fp_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_defs (package)
// Brief    : Shared widths, types and constants for the pipelined FP adder.
// Revision : 1.0
// ============================================================================
package fp_defs;

  localparam int FP_EXP   = 8;
  localparam int FP_MANT  = 23;
  localparam int FP_TAG_W = 4;
  localparam int C_BIAS   = 2 ** (FP_EXP - 1) - 1;
  // Aligned field {hidden, mant, G, R, S}; the sum adds one carry bit on top.
  localparam int FP_FW    = FP_MANT + 4;
  localparam int FP_SW    = FP_MANT + 5;
  localparam int FP_LZW   = $clog2(FP_SW + 1);

  typedef struct packed {
    logic                sign;
    logic [FP_EXP-1:0]   exp;
    logic [FP_MANT-1:0]  mant;
  } fp_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_status_t;

  localparam fp_t C_QNAN = {1'b0, {FP_EXP{1'b1}}, 1'b1, {(FP_MANT - 1){1'b0}}};
  localparam fp_t C_INF  = {1'b0, {FP_EXP{1'b1}}, {FP_MANT{1'b0}}};

  typedef struct packed {
    logic [FP_TAG_W-1:0] tag;
    logic                sign;
    logic                eff_sub;
    logic [FP_EXP-1:0]   exp;
    logic [FP_FW-1:0]    mx;
    logic [FP_FW-1:0]    my;
    logic                special;
    fp_t                 spec_res;
    fp_status_t          spec_st;
  } s1_t;

  typedef struct packed {
    logic [FP_TAG_W-1:0] tag;
    logic                sign;
    logic [FP_EXP-1:0]   exp;
    logic [FP_SW-1:0]    sum;
    logic [FP_LZW-1:0]   lzc;
    logic                special;
    fp_t                 spec_res;
    fp_status_t          spec_st;
  } s2_t;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Brief    : Combinational leading-zero counter; all-zero input yields W.
// Revision : 1.0
// ============================================================================
module fp_lzc #(
  parameter int W  = 28,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_pipe
// Brief    : 3-stage IEEE-754 adder/subtractor (align, add+LZC, norm/round).
// Revision : 1.0
// ============================================================================
module fp_add_pipe
  import fp_defs::*;
#(
  parameter int C_EXP  = FP_EXP,
  parameter int C_MANT = FP_MANT,
  parameter int TAG_W  = FP_TAG_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [C_EXP+C_MANT:0] a_i,
  input  logic [C_EXP+C_MANT:0] b_i,
  input  logic                  sub_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [C_EXP+C_MANT:0] res_o,
  output logic [3:0]            status_o,
  output logic [TAG_W-1:0]      tag_o
);

  logic                  en;
  logic [2:0]            vld_d, vld_q;
  s1_t                   s1_d, s1_q;
  s2_t                   s2_d, s2_q;
  logic [C_EXP+C_MANT:0] res_d, res_q;
  fp_status_t            st_d, st_q;
  logic [TAG_W-1:0]      tag_d, tag_q;

  assign en       = ~vld_q[2] | ready_i;
  assign ready_o  = en;
  assign valid_o  = vld_q[2];
  assign res_o    = res_q;
  assign status_o = st_q;
  assign tag_o    = tag_q;

  always_comb vld_d = {vld_q[1:0], valid_i};

  // ---------------- S1: classify, swap, align ----------------
  fp_t                a, b, x, y;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic               swap, y_zero;
  logic [C_MANT-1:0]  a_m, b_m;
  logic [C_EXP-1:0]   diff, sh;
  logic [FP_FW-1:0]   y_full;
  logic [2*FP_FW-1:0] y_ext;

  always_comb begin
    a      = fp_t'(a_i);
    b      = fp_t'(b_i);
    b.sign = b_i[C_EXP+C_MANT] ^ sub_i;
    a_zero = (a.exp == '0);
    b_zero = (b.exp == '0);
    a_inf  = (&a.exp) & (a.mant == '0);
    b_inf  = (&b.exp) & (b.mant == '0);
    a_nan  = (&a.exp) & (a.mant != '0);
    b_nan  = (&b.exp) & (b.mant != '0);
    a_snan = a_nan & ~a.mant[C_MANT-1];
    b_snan = b_nan & ~b.mant[C_MANT-1];
    a_m    = a_zero ? '0 : a.mant;
    b_m    = b_zero ? '0 : b.mant;
    swap   = {b.exp, b_m} > {a.exp, a_m};
    x      = swap ? b : a;
    y      = swap ? a : b;
    y_zero = swap ? a_zero : b_zero;
    diff   = x.exp - y.exp;
    sh     = (diff > C_EXP'(FP_FW)) ? C_EXP'(FP_FW) : diff;
    y_full = y_zero ? '0 : {1'b1, y.mant, 3'b000};
    // Shift through a double-width window so everything dropped lands in sticky.
    y_ext  = {y_full, {FP_FW{1'b0}}} >> sh;

    s1_d         = '0;
    s1_d.tag     = tag_i;
    s1_d.sign    = x.sign;
    s1_d.eff_sub = a.sign ^ b.sign;
    s1_d.exp     = x.exp;
    s1_d.mx      = {~(a_zero & b_zero), x.mant, 3'b000};
    s1_d.my      = y_ext[2*FP_FW-1 -: FP_FW] | FP_FW'(|y_ext[FP_FW-1:0]);
    s1_d.special = 1'b1;
    if (a_nan | b_nan) begin
      s1_d.spec_res        = C_QNAN;
      s1_d.spec_st.invalid = a_snan | b_snan;
    end else if (a_inf & b_inf & (a.sign != b.sign)) begin
      s1_d.spec_res        = C_QNAN;
      s1_d.spec_st.invalid = 1'b1;
    end else if (a_inf) begin
      s1_d.spec_res      = C_INF;
      s1_d.spec_res.sign = a.sign;
    end else if (b_inf) begin
      s1_d.spec_res      = C_INF;
      s1_d.spec_res.sign = b.sign;
    end else if (a_zero & b_zero) begin
      s1_d.spec_res.sign = a.sign & b.sign;
    end else begin
      s1_d.special = 1'b0;
    end
  end

  // ---------------- S2: add/subtract and count leading zeros ----------------
  logic [FP_SW-1:0]  sum;
  logic [FP_LZW-1:0] lzc;

  always_comb
    sum = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                       : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});

  fp_lzc #(.W(FP_SW)) u_lzc (
    .a_i   (sum),
    .cnt_o (lzc)
  );

  always_comb begin
    s2_d          = '0;
    s2_d.tag      = s1_q.tag;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp;
    s2_d.sum      = sum;
    s2_d.lzc      = lzc;
    s2_d.special  = s1_q.special;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.spec_st  = s1_q.spec_st;
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [FP_FW-1:0]   norm;
  logic [C_EXP+1:0]   e;
  logic [C_MANT:0]    mrnd;
  logic               grs, inc;
  int                 sh_l;

  always_comb begin
    e    = {2'b00, s2_q.exp};
    sh_l = 0;
    if (s2_q.sum[FP_SW-1]) begin
      norm = s2_q.sum[FP_SW-1:1] | FP_FW'(s2_q.sum[0]);
      e    = e + (C_EXP+2)'(1);
    end else begin
      // Leading one belongs at bit FP_FW-1; never push the exponent below 1.
      sh_l = int'(s2_q.lzc) - 1;
      if (sh_l > int'(s2_q.exp) - 1) sh_l = int'(s2_q.exp) - 1;
      if (sh_l < 0) sh_l = 0;
      norm = FP_FW'(s2_q.sum << sh_l);
      e    = e - (C_EXP+2)'(sh_l);
    end
    grs  = |norm[2:0];
    inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mrnd = {1'b0, norm[FP_FW-2:3]} + (C_MANT+1)'(inc);
    if (mrnd[C_MANT]) e = e + (C_EXP+2)'(1);

    res_d = '0;
    st_d  = '0;
    tag_d = s2_q.tag;
    if (s2_q.special) begin
      res_d = s2_q.spec_res;
      st_d  = s2_q.spec_st;
    end else if (s2_q.sum != '0) begin
      if (~norm[FP_FW-1]) begin
        res_d[C_EXP+C_MANT] = s2_q.sign;
        st_d.underflow      = 1'b1;
        st_d.inexact        = 1'b1;
      end else if (e >= (C_EXP+2)'((1 << C_EXP) - 1)) begin
        res_d         = {s2_q.sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
        st_d.overflow = 1'b1;
        st_d.inexact  = 1'b1;
      end else begin
        res_d        = {s2_q.sign, e[C_EXP-1:0], mrnd[C_MANT-1:0]};
        st_d.inexact = grs;
      end
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  vld_q <= '0;
    else if (en)  vld_q <= vld_d;
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= '0;
      st_q  <= '0;
      tag_q <= '0;
    end else if (en) begin
      res_q <= res_d;
      st_q  <= st_d;
      tag_q <= tag_d;
    end
  end

endmodule
`default_nettype wire
